dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: REQ cycles without bus_ack before abort; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 memread  input  1  load request from datapath; level, held while stall=1.
REQ-005 memwrite  input  1  store request from datapath; level, held while stall=1.
REQ-006 addr  input  32  byte address (datapath ALU result).
REQ-007 writedata  input  32  store data.
REQ-008 readdata  output  32  load result to datapath result mux.
REQ-009 stall  output  1  freeze pc and pipeline state while high.
REQ-010 bus_req  output  1  registered bus request.
REQ-011 bus_we  output  1  registered; 1=write, 0=read.
REQ-012 bus_addr  output  32  registered word address, bits[1:0]=00.
REQ-013 bus_wdata  output  32  registered store data.
REQ-014 bus_rdata  input  32  read data, valid with bus_ack.
REQ-015 bus_ack  input  1  one-cycle completion strobe.
REQ-016 err_misalign  output  1  sticky: misaligned access seen.
REQ-017 err_timeout  output  1  sticky: bus timeout seen.
REQ-018 err_clr  input  1  synchronous clear of both sticky flags.

Function
REQ-019 FSM states IDLE, REQ, DONE; one-hot or binary at implementer's choice.
REQ-020 IDLE, (memread|memwrite)=1, addr[1:0]=00: stall=1 combinationally; next edge: REQ, load bus_addr/bus_wdata/bus_we, bus_req=1.
REQ-021 memread and memwrite both high: handled as write.
REQ-022 IDLE, request with addr[1:0]!=00: no bus access, stall=0, readdata=0, err_misalign set next edge.
REQ-023 REQ: stall=1; bus_req, bus_we, bus_addr, bus_wdata held constant until bus_ack or timeout.
REQ-024 REQ with bus_ack=1: read captures bus_rdata into readdata; bus_req=0 next cycle; go DONE.
REQ-025 DONE: stall=0 for exactly one cycle (datapath commits); readdata held; next edge IDLE.
REQ-026 Minimum access latency: 2 stall cycles (IDLE detect + one REQ cycle with immediate ack).
REQ-027 Timeout counter cleared on REQ entry, increments each REQ cycle without ack; reaching TIMEOUT_CYCLES: bus_req=0, readdata=0, err_timeout set, go DONE.
REQ-028 bus_ack in timeout cycle wins: normal completion, no error.
REQ-029 bus_ack in IDLE or DONE ignored.
REQ-030 readdata changes only on load completion, misaligned load, or timeout; stores leave it unchanged.
REQ-031 err_clr and new error same cycle: error set wins.
REQ-032 No request in IDLE: stall=0, all bus outputs hold, bus_req=0.

Reset
REQ-033 rst=0 immediately forces IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, readdata=0, err flags=0, counter=0, stall=0.
REQ-034 Reset mid-REQ aborts the access without completion; a late bus_ack after reset release is ignored.

Structure
REQ-035 Package dmem_pkg holds the state enum and default TIMEOUT_CYCLES constant.
REQ-036 One sub-module dmem_timer: 16-bit clearable counter with terminal-count flag.
REQ-037 Bus output registers and readdata register are flops with asynchronous active-low reset.

Verification
REQ-038 Load addr=0x100, ack on first REQ cycle, bus_rdata=0x12345678 -> stall high 2 cycles, readdata=0x12345678, bus_we=0.
REQ-039 Store addr=0x204, writedata=0xCAFEF00D, ack after 5 REQ cycles -> bus_addr/bus_wdata stable all 5 cycles, stall high 6 cycles, readdata unchanged.
REQ-040 Load addr=0x102 -> no bus_req, stall=0, err_misalign=1 next cycle; err_clr -> 0.
REQ-041 TIMEOUT_CYCLES=4, load, no ack -> bus_req drops after 4 REQ cycles, err_timeout=1, readdata=0, one DONE cycle.
REQ-042 rst low during REQ cycle 3 -> bus_req=0 asynchronously; ack after release ignored; state IDLE.
REQ-043 memread=memwrite=1, addr=0x40 -> bus_we=1, write performed.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory controller
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int          TMR_W              = 16;

    function automatic logic is_aligned(input logic [1:0] lo);
        return lo == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - word-wide memory bus between the controller and the memory side
interface dmem_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );

endinterface

// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - clearable 16-bit cycle counter with terminal-count flag
module dmem_timer
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] limit,
    output logic             tc
);

    logic [TMR_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + TMR_W'(1);
        end
    end

    // Flags the cycle in which the count would reach the limit, so the
    // controller can abort on exactly the limit-th unanswered cycle.
    assign tc = (count_q == limit - TMR_W'(1));

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - stalls the datapath while a single load/store runs on the memory bus
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    dmem_if.master      bus,
    output logic        err_misalign,
    output logic        err_timeout,
    input  logic        err_clr
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic        req_any;
    logic        aligned;
    logic        is_load;
    logic        start;
    logic        misal;
    logic        in_req;
    logic        hit;
    logic        expire;
    logic        tc;
    logic        stall_c;
    logic [31:0] readdata_q;

    assign req_any = memread | memwrite;
    assign aligned = is_aligned(addr[1:0]);
    assign is_load = memread & ~memwrite;
    assign start   = (state_q == ST_IDLE) & req_any & aligned;
    assign misal   = (state_q == ST_IDLE) & req_any & ~aligned;
    assign in_req  = (state_q == ST_REQ);
    assign hit     = in_req & bus.bus_ack;
    assign expire  = in_req & ~bus.bus_ack & tc;

    dmem_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (in_req & ~bus.bus_ack),
        .limit (LIMIT),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_c = start;
                if (start) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                if (hit || expire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The detect-cycle stall is combinational, so reset must mask it directly.
    assign stall = rst & stall_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
        end else if (start) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= memwrite;
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_wdata <= writedata;
        end else if (hit || expire) begin
            bus.bus_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readdata_q <= '0;
        end else if (hit && !bus.bus_we) begin
            readdata_q <= bus.bus_rdata;
        end else if (expire || (misal && is_load)) begin
            readdata_q <= '0;
        end
    end

    // A misaligned load commits in its own cycle, so the zero must be visible now.
    assign readdata = (misal && is_load) ? '0 : readdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (misal) begin
                err_misalign <= 1'b1;
            end else if (err_clr) begin
                err_misalign <= 1'b0;
            end
            if (expire) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - two controllers (timeout 255 and 4) against a transaction-level model
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err_clr;
    logic        ack;
    logic [31:0] rdata;
    logic        mrd [2];
    logic        mwr [2];

    logic [31:0] rdd  [2];
    logic        stl  [2];
    logic        em   [2];
    logic        et   [2];
    logic        breq [2];
    logic        bwe  [2];
    logic [31:0] ba   [2];
    logic [31:0] bw   [2];

    always #5 clk = ~clk;

    dmem_if bif0 ();
    dmem_if bif1 ();

    assign bif0.bus_ack   = ack;
    assign bif0.bus_rdata = rdata;
    assign bif1.bus_ack   = ack;
    assign bif1.bus_rdata = rdata;
    assign breq[0] = bif0.bus_req;
    assign bwe[0]  = bif0.bus_we;
    assign ba[0]   = bif0.bus_addr;
    assign bw[0]   = bif0.bus_wdata;
    assign breq[1] = bif1.bus_req;
    assign bwe[1]  = bif1.bus_we;
    assign ba[1]   = bif1.bus_addr;
    assign bw[1]   = bif1.bus_wdata;

    dmem_ctrl #(.TIMEOUT_CYCLES(255)) dut0 (
        .clk(clk), .rst(rst), .memread(mrd[0]), .memwrite(mwr[0]),
        .addr(addr), .writedata(wdata), .readdata(rdd[0]), .stall(stl[0]),
        .bus(bif0), .err_misalign(em[0]), .err_timeout(et[0]), .err_clr(err_clr)
    );

    dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut1 (
        .clk(clk), .rst(rst), .memread(mrd[1]), .memwrite(mwr[1]),
        .addr(addr), .writedata(wdata), .readdata(rdd[1]), .stall(stl[1]),
        .bus(bif1), .err_misalign(em[1]), .err_timeout(et[1]), .err_clr(err_clr)
    );

    int tmo [2] = '{255, 4};

    // Architectural state the model tracks between transactions.
    logic [31:0] m_rd [2], m_ba [2], m_bw [2];
    logic        m_bwe [2], m_em [2], m_et [2];

    // Expected outputs for the current cycle.
    logic [31:0] x_rd [2], x_ba [2], x_bw [2];
    logic        x_stl [2], x_breq [2], x_bwe [2], x_em [2], x_et [2];
    logic        chk_en;

    int total;
    int bad;
    int stall_seen [2];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("stall", i, 32'(stl[i]), 32'(x_stl[i]));
                chk("bus_req", i, 32'(breq[i]), 32'(x_breq[i]));
                chk("bus_we", i, 32'(bwe[i]), 32'(x_bwe[i]));
                chk("bus_addr", i, ba[i], x_ba[i]);
                chk("bus_wdata", i, bw[i], x_bw[i]);
                chk("readdata", i, rdd[i], x_rd[i]);
                chk("err_misalign", i, 32'(em[i]), 32'(x_em[i]));
                chk("err_timeout", i, 32'(et[i]), 32'(x_et[i]));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = '0; m_ba[i] = '0; m_bw[i] = '0;
            m_bwe[i] = 1'b0; m_em[i] = 1'b0; m_et[i] = 1'b0;
        end
    endtask

    task automatic exp_hold(input int i, input logic s);
        x_stl[i] = s;     x_breq[i] = 1'b0;
        x_ba[i]  = m_ba[i]; x_bw[i] = m_bw[i]; x_bwe[i] = m_bwe[i];
        x_rd[i]  = m_rd[i]; x_em[i] = m_em[i]; x_et[i] = m_et[i];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Aligned access; ackd = REQ cycle (1-based) carrying bus_ack, 0 = never.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int ackd, input logic [31:0] rdv);
        int          n [2];
        logic        comp [2];
        logic [31:0] cap;
        int          len;
        cap = '0;
        for (int i = 0; i < 2; i++) begin
            comp[i] = (ackd != 0) && (ackd <= tmo[i]);
            n[i]    = comp[i] ? ackd : tmo[i];
            stall_seen[i] = 0;
        end
        len = ((n[0] > n[1]) ? n[0] : n[1]) + 3;
        addr  = a;
        wdata = wd;
        for (int t = 0; t < len; t++) begin
            ack   = (ackd != 0) && (t == ackd);
            rdata = ack ? rdv : $urandom;
            if (ack) cap = rdv;
            for (int i = 0; i < 2; i++) begin
                mrd[i] = (t <= n[i] + 1) ? rd : 1'b0;
                mwr[i] = (t <= n[i] + 1) ? wr : 1'b0;
                if (t == 0) begin
                    exp_hold(i, 1'b1);
                end else begin
                    x_ba[i] = {a[31:2], 2'b00}; x_bw[i] = wd; x_bwe[i] = wr;
                    x_em[i] = m_em[i];
                    if (t <= n[i]) begin
                        x_stl[i] = 1'b1; x_breq[i] = 1'b1;
                        x_rd[i]  = m_rd[i]; x_et[i] = m_et[i];
                    end else begin
                        x_stl[i] = 1'b0; x_breq[i] = 1'b0;
                        x_rd[i]  = comp[i] ? (wr ? m_rd[i] : cap) : 32'h0;
                        x_et[i]  = m_et[i] | ~comp[i];
                    end
                end
            end
            #2;
            for (int i = 0; i < 2; i++) stall_seen[i] += int'(stl[i]);
            next_cycle();
        end
        ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_ba[i] = {a[31:2], 2'b00}; m_bw[i] = wd; m_bwe[i] = wr;
            m_rd[i] = comp[i] ? (wr ? m_rd[i] : cap) : 32'h0;
            m_et[i] = m_et[i] | ~comp[i];
        end
    endtask

    task automatic misalign(input logic rd, input logic wr, input logic [31:0] a, input logic clr);
        logic ld;
        ld      = rd & ~wr;
        addr    = a;
        err_clr = clr;
        ack     = 1'($urandom_range(0, 1));
        rdata   = $urandom;
        for (int i = 0; i < 2; i++) begin
            mrd[i] = rd; mwr[i] = wr;
            exp_hold(i, 1'b0);
            if (ld) x_rd[i] = 32'h0;
        end
        next_cycle();
        err_clr = 1'b0;
        ack     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mrd[i] = 1'b0; mwr[i] = 1'b0;
            if (ld) m_rd[i] = 32'h0;
            m_em[i] = 1'b1;
            if (clr) m_et[i] = 1'b0;
            exp_hold(i, 1'b0);
        end
    endtask

    task automatic idle(input logic clr);
        err_clr = clr;
        ack     = 1'($urandom_range(0, 1));
        rdata   = $urandom;
        for (int i = 0; i < 2; i++) begin
            mrd[i] = 1'b0; mwr[i] = 1'b0;
            exp_hold(i, 1'b0);
        end
        next_cycle();
        err_clr = 1'b0;
        ack     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_em[i] = 1'b0; m_et[i] = 1'b0;
            end
            exp_hold(i, 1'b0);
        end
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        rst = 1'b0; addr = '0; wdata = '0; err_clr = 1'b0; ack = 1'b0; rdata = '0;
        for (int i = 0; i < 2; i++) begin
            mrd[i] = 1'b0; mwr[i] = 1'b0;
        end
        model_reset();
        repeat (2) next_cycle();

        // Held in reset with an aligned request present: nothing may stall.
        for (int i = 0; i < 2; i++) begin
            mrd[i] = 1'b1;
            exp_hold(i, 1'b0);
        end
        chk_en = 1'b1;
        next_cycle();
        for (int i = 0; i < 2; i++) mrd[i] = 1'b0;
        rst = 1'b1;
        next_cycle();

        access(1'b1, 1'b0, 32'h100, 32'hDEAD0001, 1, 32'h12345678);
        chk("lit_load_stall", 0, 32'(stall_seen[0]), 32'd2);
        chk("lit_load_rd", 0, rdd[0], 32'h12345678);
        chk("lit_load_we", 0, 32'(bwe[0]), 32'd0);

        access(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 5, 32'h0BADBEEF);
        chk("lit_store_stall", 0, 32'(stall_seen[0]), 32'd6);
        chk("lit_store_rd", 0, rdd[0], 32'h12345678);
        chk("lit_store_wdata", 0, bw[0], 32'hCAFEF00D);
        chk("lit_store_tmo_stall", 1, 32'(stall_seen[1]), 32'd5);
        chk("lit_store_tmo_err", 1, 32'(et[1]), 32'd1);
        chk("lit_store_tmo_rd", 1, rdd[1], 32'h0);
        idle(1'b1);

        misalign(1'b1, 1'b0, 32'h102, 1'b0);
        chk("lit_misal_err", 0, 32'(em[0]), 32'd1);
        chk("lit_misal_rd", 0, rdd[0], 32'h0);
        idle(1'b1);
        chk("lit_misal_clr", 0, 32'(em[0]), 32'd0);

        access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h0);
        chk("lit_tmo_stall", 1, 32'(stall_seen[1]), 32'd5);
        chk("lit_tmo_err", 1, 32'(et[1]), 32'd1);
        chk("lit_tmo_rd", 1, rdd[1], 32'h0);
        idle(1'b1);

        access(1'b1, 1'b0, 32'h20, 32'h0, 4, 32'hA5A5A5A5);
        chk("lit_ack_wins_err", 1, 32'(et[1]), 32'd0);
        chk("lit_ack_wins_rd", 1, rdd[1], 32'hA5A5A5A5);

        access(1'b1, 1'b1, 32'h40, 32'h11223344, 2, 32'h55555555);
        chk("lit_both_we", 0, 32'(bwe[0]), 32'd1);
        chk("lit_both_rd", 0, rdd[0], 32'hA5A5A5A5);

        access(1'b0, 1'b1, 32'h50, 32'h0, 6, 32'h0);
        misalign(1'b1, 1'b0, 32'h7, 1'b1);
        chk("lit_clr_race_mis", 1, 32'(em[1]), 32'd1);
        chk("lit_clr_race_tmo", 1, 32'(et[1]), 32'd0);

        // Reset during the third REQ cycle, then a stray ack after release.
        addr = 32'h300; wdata = 32'h77;
        for (int i = 0; i < 2; i++) begin
            mrd[i] = 1'b1; mwr[i] = 1'b0;
            exp_hold(i, 1'b1);
        end
        next_cycle();
        for (int t = 1; t <= 3; t++) begin
            for (int i = 0; i < 2; i++) begin
                x_stl[i] = 1'b1; x_breq[i] = 1'b1;
                x_ba[i] = 32'h300; x_bw[i] = 32'h77; x_bwe[i] = 1'b0;
            end
            if (t < 3) next_cycle();
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_async_req", i, 32'(breq[i]), 32'd0);
            chk("rst_async_stall", i, 32'(stl[i]), 32'd0);
            chk("rst_async_rd", i, rdd[i], 32'h0);
        end
        model_reset();
        for (int i = 0; i < 2; i++) begin
            mrd[i] = 1'b0;
            exp_hold(i, 1'b0);
        end
        next_cycle();
        rst = 1'b1; ack = 1'b1; rdata = 32'hFFFF0000;
        next_cycle();
        ack = 1'b0;
        next_cycle();

        for (int k = 0; k < 80; k++) begin
            int          sel;
            int          v;
            int          d;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            v   = $urandom_range(1, 3);
            a   = $urandom;
            if (sel == 0) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                misalign(v[0], v[1], a, 1'($urandom_range(0, 1)));
            end else if (sel == 1) begin
                idle(1'($urandom_range(0, 1)));
            end else begin
                d = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 8);
                access(v[0], v[1], {a[31:2], 2'b00}, $urandom, d, $urandom);
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
